sram_req_arbiter: RTL and testbench



---
 rtl/sram_req_arbiter.sv | 115 +++++++++++
 tb/tb_sram_req_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-to-one round-robin arbiter sharing one sram-like slave between inst and data ports.
// Latency: addr_ok same cycle as grant, mem_req next cycle; one transaction in flight, slave stalls hold the request register.
module sram_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic                wr;
    logic [1:0]          size;
    logic [DATA_W/8-1:0] wstrb;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  state_t state;
  req_t   req_q;
  req_t   inst_fields;
  req_t   data_fields;
  logic   owner;       // 1 = data port
  logic   last_grant;  // 1 = data port
  logic   grant_inst;
  logic   grant_data;

  assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                         addr: inst_addr, wdata: inst_wdata};
  assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};

  // On a tie the port that did not win last time is favoured.
  assign grant_data = (state == S_IDLE) && data_req && (!inst_req || !last_grant);
  assign grant_inst = (state == S_IDLE) && inst_req && (!data_req ||  last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      req_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_data) begin
            state      <= S_REQ;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            req_q      <= data_fields;
          end else if (grant_inst) begin
            state      <= S_REQ;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            req_q      <= inst_fields;
          end
        end
        // A data_ok arriving alongside addr_ok is dropped here on purpose.
        S_REQ:   if (mem_addr_ok) state <= S_WAIT;
        S_WAIT:  if (mem_data_ok) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = (state == S_WAIT) && mem_data_ok && !owner;
  assign data_data_ok = (state == S_WAIT) && mem_data_ok &&  owner;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_req   = (state == S_REQ);
  assign mem_wr    = req_q.wr;
  assign mem_size  = req_q.size;
  assign mem_wstrb = req_q.wstrb;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok, busy;

  // Slave: either a zero-wait responder (with optional addr stall) or driven by hand.
  logic slv_auto, slv_stall, man_addr_ok, man_data_ok, resp_pend;
  assign mem_addr_ok = slv_auto ? (mem_req && !slv_stall) : man_addr_ok;
  assign mem_data_ok = slv_auto ? resp_pend : man_data_ok;
  always @(posedge clk) resp_pend <= slv_auto && mem_req && mem_addr_ok;

  always #5 clk = ~clk;

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } fields_t;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is a transaction pending, has the slave taken its address, who owns it.
  bit      m_busy, m_acc, m_owner_data, m_last_data;
  fields_t m_fields;
  bit      s_reset, s_win_inst, s_win_data, s_aok, s_dok;
  fields_t s_inst_f, s_data_f;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_neg();
    bit w_inst, w_data;
    fields_t out_f;
    @(negedge clk);
    w_data = data_req && (!inst_req || !m_last_data);
    w_inst = inst_req && (!data_req ||  m_last_data);
    out_f  = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
    chk("inst_addr_ok", inst_addr_ok, !m_busy && w_inst);
    chk("data_addr_ok", data_addr_ok, !m_busy && w_data);
    chk("inst_data_ok", inst_data_ok, m_busy && m_acc && mem_data_ok && !m_owner_data);
    chk("data_data_ok", data_data_ok, m_busy && m_acc && mem_data_ok &&  m_owner_data);
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    chk("mem_req", mem_req, m_busy && !m_acc);
    chk("busy", busy, m_busy);
    chk("mem_fields", out_f, m_fields);
    s_reset    = reset;
    s_win_inst = w_inst;
    s_win_data = w_data;
    s_aok      = mem_addr_ok;
    s_dok      = mem_data_ok;
    s_inst_f   = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    s_data_f   = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  endtask

  task automatic tick_pos();
    @(posedge clk);
    if (s_reset) begin
      m_busy = 0; m_acc = 0; m_owner_data = 0; m_last_data = 0; m_fields = '0;
    end else if (!m_busy) begin
      if (s_win_data || s_win_inst) begin
        m_busy       = 1;
        m_acc        = 0;
        m_owner_data = s_win_data;
        m_last_data  = s_win_data;
        m_fields     = s_win_data ? s_data_f : s_inst_f;
      end
    end else if (!m_acc) begin
      if (s_aok) m_acc = 1;
    end else if (s_dok) begin
      m_busy = 0;
    end
    #1;
  endtask

  task automatic cyc();
    tick_neg();
    tick_pos();
  endtask

  initial begin
    reset = 1; inst_req = 0; data_req = 0;
    inst_wr = 0; inst_size = 2; inst_wstrb = 4'hF; inst_addr = 0; inst_wdata = 0;
    data_wr = 0; data_size = 2; data_wstrb = 4'hF; data_addr = 0; data_wdata = 0;
    slv_auto = 1; slv_stall = 0; man_addr_ok = 0; man_data_ok = 0; mem_rdata = 32'hDEADBEEF;
    m_busy = 0; m_acc = 0; m_owner_data = 0; m_last_data = 0; m_fields = '0;
    @(posedge clk); #1;
    tick_neg();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    tick_pos();
    reset = 0;
    cyc();

    // Single inst read through a zero-wait slave.
    inst_req = 1; inst_addr = 32'h1C000000; inst_size = 2;
    tick_neg(); chk("t1_inst_aok", inst_addr_ok, 1'b1); chk("t1_data_aok", data_addr_ok, 1'b0); tick_pos();
    inst_req = 0;
    tick_neg(); chk("t1_mem_req", mem_req, 1'b1); chk("t1_mem_addr", mem_addr, 32'h1C000000);
    chk("t1_mem_size", mem_size, 2'd2); tick_pos();
    tick_neg(); chk("t1_inst_dok", inst_data_ok, 1'b1); chk("t1_rdata", inst_rdata, 32'hDEADBEEF);
    chk("t1_data_dok", data_data_ok, 1'b0); tick_pos();
    tick_neg(); chk("t1_idle", busy, 1'b0); tick_pos();

    // Tie after reset: data first, then strict alternation over four transactions.
    inst_req = 1; inst_addr = 32'h200; inst_wr = 0;
    data_req = 1; data_addr = 32'h100; data_wr = 1; data_wstrb = 4'h3; data_wdata = 32'h1234; data_size = 1;
    for (int k = 0; k < 4; k++) begin
      tick_neg();
      chk("t2_data_grant", data_addr_ok, (k % 2) == 0);
      chk("t2_inst_grant", inst_addr_ok, (k % 2) == 1);
      tick_pos();
      if (k == 3) begin inst_req = 0; data_req = 0; end
      tick_neg();
      if (k == 0) begin chk("t2_wstrb", mem_wstrb, 4'h3); chk("t2_wdata", mem_wdata, 32'h1234); end
      if (k == 1) chk("t2_addr", mem_addr, 32'h200);
      tick_pos();
      cyc();
    end

    // Slave stalls addr_ok for 5 cycles while data waits.
    slv_stall = 1; inst_req = 1; inst_addr = 32'h40; inst_wdata = 32'h5A5A;
    tick_neg(); chk("t3_inst_aok", inst_addr_ok, 1'b1); tick_pos();
    inst_req = 0; data_req = 1; data_addr = 32'h80; data_wr = 0;
    for (int k = 0; k < 5; k++) begin
      tick_neg();
      chk("t3_mem_req", mem_req, 1'b1); chk("t3_mem_addr", mem_addr, 32'h40);
      chk("t3_data_aok", data_addr_ok, 1'b0);
      tick_pos();
    end
    slv_stall = 0;
    cyc();
    tick_neg(); chk("t3_inst_dok", inst_data_ok, 1'b1); chk("t3_data_aok_wait", data_addr_ok, 1'b0); tick_pos();
    tick_neg(); chk("t3_data_aok_idle", data_addr_ok, 1'b1); tick_pos();
    data_req = 0;
    cyc(); cyc();

    // Spurious and coincident responses with a hand-driven slave.
    slv_auto = 0; man_data_ok = 1; mem_rdata = 32'hCAFEF00D;
    tick_neg(); chk("t4_idle_dok", inst_data_ok | data_data_ok, 1'b0); tick_pos();
    man_data_ok = 0; inst_req = 1;
    cyc();
    inst_req = 0; man_data_ok = 1;
    tick_neg(); chk("t4_req_dok", inst_data_ok, 1'b0); tick_pos();
    man_data_ok = 0;
    tick_neg(); chk("t4_still_req", mem_req, 1'b1); tick_pos();
    man_addr_ok = 1; man_data_ok = 1;
    tick_neg(); chk("t4_both_dok", inst_data_ok, 1'b0); tick_pos();
    man_addr_ok = 0;
    tick_neg(); chk("t4_wait_dok", inst_data_ok, 1'b1); chk("t4_rdata", inst_rdata, 32'hCAFEF00D); tick_pos();
    man_data_ok = 0;
    cyc();

    // Reset while waiting on the response, then a late data_ok.
    data_req = 1;
    cyc();
    data_req = 0; man_addr_ok = 1;
    cyc();
    man_addr_ok = 0;
    tick_neg(); chk("t5_in_wait", busy, 1'b1); tick_pos();
    reset = 1;
    cyc();
    reset = 0; man_data_ok = 1;
    tick_neg();
    chk("t5_mem_req", mem_req, 1'b0); chk("t5_busy", busy, 1'b0);
    chk("t5_no_dok", inst_data_ok | data_data_ok, 1'b0);
    tick_pos();
    man_data_ok = 0; inst_req = 1; data_req = 1;
    tick_neg(); chk("t5_tie_data", data_addr_ok, 1'b1); chk("t5_tie_inst", inst_addr_ok, 1'b0); tick_pos();
    inst_req = 0; data_req = 0; man_addr_ok = 1;
    cyc();
    man_addr_ok = 0; man_data_ok = 1;
    cyc();
    man_data_ok = 0;

    // Bounded drain: the arbiter must be idle again.
    begin
      int n;
      n = 0;
      while (busy && n < 20) begin cyc(); n++; end
      chk("drain_idle", busy, 1'b0);
    end
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
